// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants and types for the register-file port arbiter.
// Holds the default widths, the FSM state encoding and the requester IDs.
package regfile_port_arbiter_pkg;

  localparam int unsigned AW_DEF       = 5;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned LOCK_MAX_DEF = 16;

  typedef enum logic {
    ST_RR    = 1'b0,
    ST_LOCKB = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of requester A/B request fields, grant/return signals and register-file control.
// The arbiter uses the slave modport; the requesters and the register file use master.
interface regfile_port_arbiter_if
  import regfile_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_waddr, a_raddr1, a_raddr2;
  logic [DW-1:0] a_wdata;

  logic          b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [AW-1:0] b_waddr, b_raddr1, b_raddr2;
  logic [DW-1:0] b_wdata;

  logic [DW-1:0] rdata1, rdata2;

  logic          RegW;
  logic [AW-1:0] DR, SR1, SR2;
  logic [DW-1:0] Reg_In;
  logic [DW-1:0] ReadReg1, ReadReg2;

  modport slave (
    input  a_req, a_we, a_waddr, a_wdata, a_raddr1, a_raddr2,
    input  b_req, b_we, b_waddr, b_wdata, b_raddr1, b_raddr2, b_lock,
    input  ReadReg1, ReadReg2,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata1, rdata2,
    output RegW, DR, SR1, SR2, Reg_In
  );

  modport master (
    output a_req, a_we, a_waddr, a_wdata, a_raddr1, a_raddr2,
    output b_req, b_we, b_waddr, b_wdata, b_raddr1, b_raddr2, b_lock,
    output ReadReg1, ReadReg2,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata1, rdata2,
    input  RegW, DR, SR1, SR2, Reg_In
  );

endinterface

// File: rtl/regfile_port_arbiter_arb.sv
// Two-way round-robin grant with a last-grant pointer.
// force_b hands the slot to B unconditionally (A is never granted while it is high).
module rr_arb2
  import regfile_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_req,
  input  logic b_req,
  input  logic force_b,
  output logic a_gnt,
  output logic b_gnt
);

  req_id_e last_q;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (force_b) begin
        b_gnt = b_req;
      end else if (a_req && b_req) begin
        a_gnt = (last_q == REQ_B);
        b_gnt = (last_q == REQ_A);
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Reset points at B so A wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_B;
    end else if (a_gnt) begin
      last_q <= REQ_A;
    end else if (b_gnt) begin
      last_q <= REQ_B;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the register file's single access slot between requesters A and B,
// with bounded B locking, $0 write suppression and same-cycle write forwarding.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input logic                  CLK,
  input logic                  RST,
  regfile_port_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_hold;
  logic          a_gnt, b_gnt;

  logic          reg_w;
  logic [AW-1:0] dr, sr1, sr2;
  logic [DW-1:0] reg_in;

  logic          a_rvalid_q, b_rvalid_q, fwd1_q, fwd2_q;
  logic [DW-1:0] wdata_q;

  assign lock_hold = (state_q == ST_LOCKB);

  rr_arb2 u_arb (
    .clk    (CLK),
    .rst    (RST),
    .a_req  (bus.a_req),
    .b_req  (bus.b_req),
    .force_b(lock_hold),
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RR;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // lock_cnt counts B grants in the current locked run, including the entry grant.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ST_RR: begin
        if (b_gnt && bus.b_lock && (LOCK_MAX > 1)) begin
          state_d    = ST_LOCKB;
          lock_cnt_d = CW'(1);
        end
      end
      ST_LOCKB: begin
        if (!b_gnt || !bus.b_lock || ((lock_cnt_q + CW'(1)) >= CW'(LOCK_MAX))) begin
          state_d    = ST_RR;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = ST_RR;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    reg_w  = 1'b0;
    dr     = '0;
    sr1    = '0;
    sr2    = '0;
    reg_in = '0;
    if (a_gnt) begin
      reg_w  = bus.a_we && (bus.a_waddr != '0);
      dr     = bus.a_waddr;
      sr1    = bus.a_raddr1;
      sr2    = bus.a_raddr2;
      reg_in = bus.a_wdata;
    end else if (b_gnt) begin
      reg_w  = bus.b_we && (bus.b_waddr != '0);
      dr     = bus.b_waddr;
      sr1    = bus.b_raddr1;
      sr2    = bus.b_raddr2;
      reg_in = bus.b_wdata;
    end
  end

  // The register file returns the pre-write value, so remember which ports must see the new one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      a_rvalid_q <= a_gnt;
      b_rvalid_q <= b_gnt;
      fwd1_q     <= reg_w && (dr == sr1);
      fwd2_q     <= reg_w && (dr == sr2);
      wdata_q    <= reg_in;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.rdata1   = fwd1_q ? wdata_q : bus.ReadReg1;
  assign bus.rdata2   = fwd2_q ? wdata_q : bus.ReadReg2;
  assign bus.RegW     = reg_w;
  assign bus.DR       = dr;
  assign bus.SR1      = sr1;
  assign bus.SR2      = sr2;
  assign bus.Reg_In   = reg_in;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: behavioural register file plus a grant/readback model
// in which reads simply return the newest register contents.
module tb_regfile_port_arbiter;
  import regfile_port_arbiter_pkg::*;

  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;
  localparam int unsigned LOCK_MAX = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  regfile_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  regfile_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Register file: synchronous read of the pre-write value; poke preloads contents.
  logic [DW-1:0] regs [32];
  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;

  always @(posedge CLK) begin
    bus.ReadReg1 <= regs[bus.SR1];
    bus.ReadReg2 <= regs[bus.SR2];
    if (poke_en) regs[poke_addr] <= poke_data;
    else if (bus.RegW === 1'b1) regs[bus.DR] <= bus.Reg_In;
  end

  // Reference model state.
  logic [DW-1:0] mregs [32];
  bit            m_last_b, m_locked;
  int            m_run;
  logic          exp_a, exp_b, exp_regw, exp_arv, exp_brv;
  logic [AW-1:0] exp_dr, exp_sr1, exp_sr2;
  logic [DW-1:0] exp_regin, exp_rd1, exp_rd2;
  int            n_checks, n_pass;

  task automatic idle();
    bus.a_req = 0; bus.a_we = 0; bus.a_waddr = 0; bus.a_wdata = 0;
    bus.a_raddr1 = 0; bus.a_raddr2 = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_waddr = 0; bus.b_wdata = 0;
    bus.b_raddr1 = 0; bus.b_raddr2 = 0; bus.b_lock = 0;
  endtask

  task automatic predict();
    exp_a = 0; exp_b = 0;
    if (!RST) begin
      if (m_locked) exp_b = bus.b_req;
      else if (bus.a_req && bus.b_req) begin
        exp_a = m_last_b; exp_b = !m_last_b;
      end else begin
        exp_a = bus.a_req; exp_b = bus.b_req;
      end
    end
    exp_regw = 0; exp_dr = 0; exp_sr1 = 0; exp_sr2 = 0; exp_regin = 0;
    if (exp_a) begin
      exp_regw = bus.a_we && (bus.a_waddr != 0); exp_dr = bus.a_waddr;
      exp_sr1 = bus.a_raddr1; exp_sr2 = bus.a_raddr2; exp_regin = bus.a_wdata;
    end else if (exp_b) begin
      exp_regw = bus.b_we && (bus.b_waddr != 0); exp_dr = bus.b_waddr;
      exp_sr1 = bus.b_raddr1; exp_sr2 = bus.b_raddr2; exp_regin = bus.b_wdata;
    end
  endtask

  // Advance one clock; afterwards exp_* describe what the DUT returns this cycle.
  task automatic tick();
    predict();
    @(posedge CLK);
    if (poke_en) mregs[poke_addr] = poke_data;
    if (RST) begin
      m_last_b = 1; m_locked = 0; m_run = 0; exp_arv = 0; exp_brv = 0;
    end else begin
      exp_arv = exp_a; exp_brv = exp_b;
      if (exp_regw) mregs[exp_dr] = exp_regin;
      exp_rd1 = mregs[exp_sr1]; exp_rd2 = mregs[exp_sr2];
      if (exp_a) m_last_b = 0;
      if (exp_b) begin
        m_last_b = 1;
        m_run    = m_locked ? m_run + 1 : 1;
        m_locked = bus.b_lock && (m_run < LOCK_MAX);
      end else begin
        m_locked = 0;
      end
    end
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    poke_en = 1; poke_addr = addr; poke_data = data;
    tick();
    poke_en = 0;
  endtask

  task automatic apply_reset();
    RST = 1; idle(); tick(); RST = 0;
  endtask

  task automatic test_reset();
    RST = 1; idle();
    bus.a_req = 1; bus.a_we = 1; bus.a_waddr = 9; bus.b_req = 1; bus.b_we = 1; bus.b_waddr = 3;
    #1;
    n_checks++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b00) $display("FAIL reset_gnt got %b exp 00", {bus.a_gnt, bus.b_gnt});
    else n_pass++;
    n_checks++;
    if (bus.RegW !== 1'b0) $display("FAIL reset_regw got %b exp 0", bus.RegW);
    else n_pass++;
    for (int i = 0; i < 32; i++) poke(AW'(i), (i == 0) ? '0 : DW'($urandom));
    n_checks++;
    if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00)
      $display("FAIL reset_rvalid got %b exp 00", {bus.a_rvalid, bus.b_rvalid});
    else n_pass++;
    RST = 0; idle();
  endtask

  task automatic test_single_write();
    idle();
    bus.a_req = 1; bus.a_we = 1; bus.a_waddr = 5; bus.a_wdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({bus.a_gnt, bus.b_gnt, bus.RegW} !== 3'b101)
      $display("FAIL single_gnt_regw got %b exp 101", {bus.a_gnt, bus.b_gnt, bus.RegW});
    else n_pass++;
    n_checks++;
    if ({bus.DR, bus.Reg_In} !== {5'd5, 32'hDEADBEEF})
      $display("FAIL single_dr_regin got %h/%h exp 05/deadbeef", bus.DR, bus.Reg_In);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.a_rvalid, bus.b_rvalid} !== 2'b10)
      $display("FAIL single_rvalid got %b exp 10", {bus.a_rvalid, bus.b_rvalid});
    else n_pass++;
    idle();
  endtask

  task automatic test_round_robin();
    logic [1:0] pat;
    apply_reset();
    bus.a_req = 1; bus.b_req = 1;
    for (int i = 0; i < 4; i++) begin
      bus.a_raddr1 = AW'($urandom); bus.b_raddr1 = AW'($urandom);
      pat = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      n_checks++;
      if ({bus.a_gnt, bus.b_gnt} !== pat)
        $display("FAIL rr_gnt%0d got %b exp %b", i, {bus.a_gnt, bus.b_gnt}, pat);
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.a_rvalid, bus.b_rvalid} !== pat || bus.rdata1 !== exp_rd1)
        $display("FAIL rr_ret%0d got %b/%h exp %b/%h", i, {bus.a_rvalid, bus.b_rvalid},
                 bus.rdata1, pat, exp_rd1);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_forwarding();
    idle();
    poke(4, 32'h55);
    bus.a_req = 1; bus.a_we = 1; bus.a_waddr = 3; bus.a_wdata = 32'h1234;
    bus.a_raddr1 = 3; bus.a_raddr2 = 4;
    tick();
    n_checks++;
    if ({bus.rdata1, bus.rdata2} !== {32'h1234, 32'h55})
      $display("FAIL fwd_rdata got %h/%h exp 00001234/00000055", bus.rdata1, bus.rdata2);
    else n_pass++;
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    bus.a_req = 1; bus.a_we = 1; bus.a_waddr = 0; bus.a_wdata = 32'hFFFF_FFFF;
    bus.a_raddr1 = 0; bus.a_raddr2 = 0;
    #1;
    n_checks++;
    if (bus.RegW !== 1'b0) $display("FAIL zero_regw got %b exp 0", bus.RegW);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.a_rvalid, bus.rdata1} !== {1'b1, 32'h0})
      $display("FAIL zero_rdata got %b/%h exp 1/00000000", bus.a_rvalid, bus.rdata1);
    else n_pass++;
    idle();
  endtask

  task automatic test_lock_max();
    logic [1:0] pat;
    apply_reset();
    bus.a_req = 1; bus.b_req = 1; bus.b_lock = 1;
    // A takes the first contention, then B holds the slot for LOCK_MAX grants.
    for (int i = 0; i < LOCK_MAX + 2; i++) begin
      pat = (i == 0 || i == LOCK_MAX + 1) ? 2'b10 : 2'b01;
      #1;
      n_checks++;
      if ({bus.a_gnt, bus.b_gnt} !== pat)
        $display("FAIL lockmax_gnt%0d got %b exp %b", i, {bus.a_gnt, bus.b_gnt}, pat);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_lock_drop();
    logic [1:0] pat;
    bus.a_req = 1; bus.b_req = 1;
    for (int i = 0; i < 4; i++) begin
      bus.b_lock = (i < 2);
      pat = (i < 3) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if ({bus.a_gnt, bus.b_gnt} !== pat)
        $display("FAIL lockdrop_gnt%0d got %b exp %b", i, {bus.a_gnt, bus.b_gnt}, pat);
      else n_pass++;
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.b_req = 1; bus.b_lock = 1; bus.b_we = 1; bus.b_waddr = 7; bus.b_wdata = 32'hA5A5;
    tick();
    RST = 1;
    #1;
    n_checks++;
    if ({bus.a_gnt, bus.b_gnt, bus.RegW} !== 3'b000)
      $display("FAIL midrst_out got %b exp 000", {bus.a_gnt, bus.b_gnt, bus.RegW});
    else n_pass++;
    tick();
    n_checks++;
    if (bus.b_rvalid !== 1'b0) $display("FAIL midrst_rvalid got %b exp 0", bus.b_rvalid);
    else n_pass++;
    RST = 0; bus.a_req = 1; bus.b_lock = 0; bus.b_we = 0;
    #1;
    n_checks++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10)
      $display("FAIL midrst_first got %b exp 10", {bus.a_gnt, bus.b_gnt});
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 39) == 0);
      bus.a_req = ($urandom_range(0, 3) != 0); bus.a_we = $urandom_range(0, 1);
      bus.a_waddr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      bus.a_wdata = $urandom; bus.a_raddr1 = AW'($urandom); bus.a_raddr2 = AW'($urandom);
      bus.b_req = ($urandom_range(0, 3) != 0); bus.b_we = $urandom_range(0, 1);
      bus.b_waddr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      bus.b_wdata = $urandom; bus.b_raddr1 = AW'($urandom); bus.b_raddr2 = AW'($urandom);
      bus.b_lock = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) bus.a_raddr1 = bus.a_waddr;
      if ($urandom_range(0, 3) == 0) bus.b_raddr2 = bus.b_waddr;
      predict();
      #1;
      n_checks++;
      if ({bus.a_gnt, bus.b_gnt, bus.RegW} !== {exp_a, exp_b, exp_regw})
        $display("FAIL rand_gnt%0d got %b exp %b", i, {bus.a_gnt, bus.b_gnt, bus.RegW},
                 {exp_a, exp_b, exp_regw});
      else n_pass++;
      n_checks++;
      if ({bus.DR, bus.SR1, bus.SR2, bus.Reg_In} !== {exp_dr, exp_sr1, exp_sr2, exp_regin})
        $display("FAIL rand_ctl%0d got %h exp %h", i, {bus.DR, bus.SR1, bus.SR2, bus.Reg_In},
                 {exp_dr, exp_sr1, exp_sr2, exp_regin});
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.a_rvalid, bus.b_rvalid} !== {exp_arv, exp_brv})
        $display("FAIL rand_rvalid%0d got %b exp %b", i, {bus.a_rvalid, bus.b_rvalid},
                 {exp_arv, exp_brv});
      else n_pass++;
      if (exp_arv || exp_brv) begin
        n_checks++;
        if ({bus.rdata1, bus.rdata2} !== {exp_rd1, exp_rd2})
          $display("FAIL rand_rdata%0d got %h/%h exp %h/%h", i, bus.rdata1, bus.rdata2,
                   exp_rd1, exp_rd2);
        else n_pass++;
      end
    end
    RST = 0;
    idle();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    m_last_b = 1; m_locked = 0; m_run = 0; exp_arv = 0; exp_brv = 0;
    exp_rd1 = '0; exp_rd2 = '0;
    poke_en = 0; poke_addr = '0; poke_data = '0;
    RST = 1;
    idle();
    test_reset();
    test_single_write();
    test_round_robin();
    test_forwarding();
    test_zero_reg();
    test_lock_max();
    test_lock_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
